// File: rtl/instr_cache.sv
// instr_cache: direct-mapped read-only instruction cache with line refill from memory
// and whole-cache invalidate; hits are answered combinationally from Address_IN.
module instr_cache #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [31:0] Address_IN,
    input  logic        Flush_IN,
    output logic [31:0] Instruction_OUT,
    output logic        Stall_OUT,
    output logic        MemRead_OUT,
    output logic [31:0] MemAddress_OUT,
    input  logic [31:0] MemData_IN,
    input  logic        MemValid_IN
);
    localparam int OW = $clog2(WORDS);
    localparam int IW = $clog2(LINES);
    localparam int TW = 30 - OW - IW;

    typedef enum logic {IDLE, REFILL} state_t;

    state_t           state, state_nx;
    logic [LINES-1:0] valid;
    logic [TW-1:0]    tags [LINES];
    logic [31:0]      data [LINES*WORDS];
    logic [TW-1:0]    base_tag;
    logic [IW-1:0]    base_idx;
    logic [OW-1:0]    cnt;
    logic             pending;
    logic [OW-1:0]    a_off;
    logic [IW-1:0]    a_idx;
    logic [TW-1:0]    a_tag;
    logic             hit;
    logic             done;
    logic             unused_ok;

    assign a_off     = Address_IN[OW+1:2];
    assign a_idx     = Address_IN[OW+IW+1:OW+2];
    assign a_tag     = Address_IN[31:OW+IW+2];
    assign hit       = valid[a_idx] && tags[a_idx] == a_tag;
    assign done      = state == REFILL && MemValid_IN && cnt == OW'(WORDS-1);
    assign unused_ok = &{1'b0, Address_IN[1:0]};

    always_comb begin
        state_nx        = state;
        Stall_OUT       = 1'b0;
        Instruction_OUT = '0;
        MemRead_OUT     = 1'b0;
        MemAddress_OUT  = '0;
        if (state == IDLE) begin
            state_nx        = hit ? IDLE : REFILL;
            Stall_OUT       = !hit;
            Instruction_OUT = hit ? data[{a_idx, a_off}] : '0;
        end else begin
            state_nx       = done ? IDLE : REFILL;
            Stall_OUT      = 1'b1;
            MemRead_OUT    = 1'b1;
            MemAddress_OUT = {base_tag, base_idx, cnt, 2'b00};
        end
        // While reset is held the pipeline must see neither a stall nor stale data
        if (!RESET) begin
            Stall_OUT       = 1'b0;
            Instruction_OUT = '0;
            MemRead_OUT     = 1'b0;
            MemAddress_OUT  = '0;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state    <= IDLE;
            valid    <= '0;
            cnt      <= '0;
            pending  <= 1'b0;
            base_tag <= '0;
            base_idx <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE) begin
                if (!hit) begin
                    base_tag <= a_tag;
                    base_idx <= a_idx;
                    cnt      <= '0;
                end
                if (Flush_IN)
                    valid <= '0;
            end else begin
                if (MemValid_IN)
                    cnt <= cnt + 1'b1;
                // A flush seen at any point of the refill leaves the whole cache invalid
                if (done) begin
                    valid   <= (pending || Flush_IN) ? '0 : valid | (LINES'(1) << base_idx);
                    pending <= 1'b0;
                end else if (Flush_IN) begin
                    pending <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (state == REFILL && MemValid_IN) begin
            data[{base_idx, cnt}] <= MemData_IN;
            if (done)
                tags[base_idx] <= base_tag;
        end
    end
endmodule

// File: tb/tb_instr_cache.sv
// tb_instr_cache: randomized scoreboard bench for instr_cache against a line-presence
// reference model and a deterministic memory image.
module tb_instr_cache;
    localparam int LINES = 16;
    localparam int WORDS = 4;
    localparam int LB    = 4 * WORDS;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic [31:0] Address_IN;
    logic        Flush_IN;
    logic [31:0] Instruction_OUT;
    logic        Stall_OUT;
    logic        MemRead_OUT;
    logic [31:0] MemAddress_OUT;
    logic [31:0] MemData_IN;
    logic        MemValid_IN;

    instr_cache #(.LINES(LINES), .WORDS(WORDS)) dut (
        .CLOCK(CLOCK),
        .RESET(RESET),
        .Address_IN(Address_IN),
        .Flush_IN(Flush_IN),
        .Instruction_OUT(Instruction_OUT),
        .Stall_OUT(Stall_OUT),
        .MemRead_OUT(MemRead_OUT),
        .MemAddress_OUT(MemAddress_OUT),
        .MemData_IN(MemData_IN),
        .MemValid_IN(MemValid_IN)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic [31:0] data;
        int          stalls;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] addr_q[$];
    int          wait_q[$];
    bit          present[int unsigned];
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, want);
        end
    endtask

    // Installing a line evicts whichever line shares its slot
    task automatic install(input int unsigned line);
        int unsigned kill[$];
        foreach (present[k])
            if (k % LINES == line % LINES)
                kill.push_back(k);
        foreach (kill[i])
            present.delete(kill[i]);
        present[line] = 1'b1;
    endtask

    task automatic fetch(input logic [31:0] a, input bit rnd, input int wpos, input int wlen,
                         input bit fli, input bit flr);
        int unsigned line;
        bit   hit;
        bit   fr;
        int   nref, tot, w, n;
        exp_t e;
        line = a / LB;
        hit  = present.exists(line);
        fr   = flr && !hit;
        nref = hit ? 0 : (fr ? 2 : 1);
        tot  = 0;
        for (int r = 0; r < nref; r++)
            for (int b = 0; b < WORDS; b++) begin
                if (rnd)
                    w = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
                else
                    w = (r == 0 && b == wpos) ? wlen : 0;
                wait_q.push_back(w);
                addr_q.push_back(32'(line * LB + b * 4));
                tot += w;
            end
        e.data   = mem_word(a);
        e.stalls = nref * (1 + WORDS) + tot;
        exp_q.push_back(e);
        if (fli)
            present.delete();
        if (nref > 0) begin
            if (fr)
                present.delete();
            install(line);
        end
        Address_IN = a;
        Flush_IN   = fli;
        n = 0;
        forever begin
            @(negedge CLOCK);
            if (!Stall_OUT)
                break;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL timeout: %h still stalled after %0d cycles, required %0d", a, n, e.stalls);
                break;
            end
            @(posedge CLOCK);
            #1;
            Flush_IN = fr && n == 1;
        end
        @(posedge CLOCK);
        #1;
        Flush_IN = 1'b0;
    endtask

    // Memory: serves the word at MemAddress_OUT after the scripted number of wait cycles
    initial begin : memory
        int wl;
        bit loaded;
        wl = 0;
        loaded = 1'b0;
        MemValid_IN = 1'b0;
        MemData_IN  = '0;
        forever begin
            @(negedge CLOCK);
            if (!RESET) begin
                loaded = 1'b0;
                MemValid_IN = 1'b0;
            end else if (MemRead_OUT) begin
                if (addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mem_req: unexpected read of %h", MemAddress_OUT);
                    MemValid_IN = 1'b0;
                end else begin
                    check("mem_addr", MemAddress_OUT, addr_q[0]);
                    if (!loaded) begin
                        wl = wait_q.size() != 0 ? wait_q.pop_front() : 0;
                        loaded = 1'b1;
                    end
                    if (wl > 0) begin
                        wl--;
                        MemValid_IN = 1'b0;
                    end else begin
                        MemValid_IN = 1'b1;
                        MemData_IN  = mem_word(MemAddress_OUT);
                        void'(addr_q.pop_front());
                        loaded = 1'b0;
                    end
                end
            end else begin
                MemValid_IN = 1'b0;
                check("mem_addr_idle", MemAddress_OUT, 32'h0);
            end
        end
    end

    // Monitor: every non-stalled cycle delivers the oldest outstanding fetch
    initial begin : monitor
        int   sc;
        exp_t e;
        sc = 0;
        forever begin
            @(negedge CLOCK);
            if (!RESET) begin
                sc = 0;
            end else if (Stall_OUT) begin
                sc++;
                check("nop_while_stalled", Instruction_OUT, 32'h0);
            end else begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL delivery: unexpected instruction %h", Instruction_OUT);
                end else begin
                    e = exp_q.pop_front();
                    check("instr", Instruction_OUT, e.data);
                    check("stall_cycles", 32'(sc), 32'(e.stalls));
                    check("memread_on_hit", {31'h0, MemRead_OUT}, 32'h0);
                end
                sc = 0;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got %0d errors required 0", errors);
        $fatal(1, "watchdog");
    end

    initial begin : driver
        logic [31:0] a;
        bit fli, flr;
        RESET      = 1'b0;
        Flush_IN   = 1'b0;
        Address_IN = 32'hBFC0_0000;
        repeat (2) @(negedge CLOCK);
        check("reset_stall", {31'h0, Stall_OUT}, 32'h0);
        check("reset_instr", Instruction_OUT, 32'h0);
        check("reset_memread", {31'h0, MemRead_OUT}, 32'h0);
        check("reset_memaddr", MemAddress_OUT, 32'h0);
        @(posedge CLOCK);
        #1;
        RESET = 1'b1;
        fetch(32'hBFC0_0000, 0, -1, 0, 0, 0);
        fetch(32'hBFC0_0004, 0, -1, 0, 0, 0);
        fetch(32'hBFC0_0008, 0, -1, 0, 0, 0);
        fetch(32'hBFC0_000C, 0, -1, 0, 0, 0);
        fetch(32'hBFC0_0100, 0, -1, 0, 0, 0);
        fetch(32'hBFC0_0000, 0, -1, 0, 0, 0);
        fetch(32'hBFC0_0200, 0, 2, 3, 0, 0);
        fetch(32'hBFC0_0010, 0, -1, 0, 0, 0);
        fetch(32'hBFC0_0024, 0, -1, 0, 0, 0);
        fetch(32'hBFC0_0000, 0, -1, 0, 0, 1);
        fetch(32'hBFC0_0010, 0, -1, 0, 0, 0);
        fetch(32'hBFC0_0014, 0, -1, 0, 1, 0);
        fetch(32'hBFC0_0018, 0, -1, 0, 0, 0);
        for (int i = 0; i < 300; i++) begin
            a   = ($urandom_range(0, 3) == 0) ? 32'h0040_0000 + 32'($urandom_range(0, 63)) * 4
                                              : 32'hBFC0_0000 + 32'($urandom_range(0, 255)) * 4;
            fli = $urandom_range(0, 15) == 0;
            flr = !fli && $urandom_range(0, 11) == 0;
            fetch(a, 1, -1, 0, fli, flr);
        end
        // Reset during the second word of a refill aborts it and leaves the line invalid
        a = 32'h1234_0040;
        for (int b = 0; b < WORDS; b++) begin
            addr_q.push_back(a + 32'(b * 4));
            wait_q.push_back(0);
        end
        Address_IN = a;
        @(posedge CLOCK);
        #1;
        @(posedge CLOCK);
        #1;
        check("refill_memread", {31'h0, MemRead_OUT}, 32'h1);
        check("refill_word1_addr", MemAddress_OUT, a + 32'h4);
        RESET = 1'b0;
        #1;
        check("abort_memread", {31'h0, MemRead_OUT}, 32'h0);
        check("abort_stall", {31'h0, Stall_OUT}, 32'h0);
        check("abort_instr", Instruction_OUT, 32'h0);
        check("abort_memaddr", MemAddress_OUT, 32'h0);
        addr_q.delete();
        wait_q.delete();
        exp_q.delete();
        present.delete();
        repeat (2) @(negedge CLOCK);
        @(posedge CLOCK);
        #1;
        RESET = 1'b1;
        fetch(a, 0, -1, 0, 0, 0);
        fetch(a + 32'h8, 0, -1, 0, 0, 0);
        check("pending_deliveries", 32'(exp_q.size()), 32'h0);
        check("pending_mem_reads", 32'(addr_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
